// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU (and/or/add/sub/slt/sltu/xor/nor)
// producing result, zero and signed-overflow flags.

module alu_pipe_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);
    logic [WIDTH-1:0] w_b;
    logic             w_sa;
    logic             w_sb;
    logic             w_ss;
    assign w_b   = i_sub ? ~i_b : i_b;
    assign o_sum = i_a + w_b + {{(WIDTH-1){1'b0}}, i_sub};
    assign w_sa  = i_a[WIDTH-1];
    assign w_sb  = i_b[WIDTH-1];
    assign w_ss  = o_sum[WIDTH-1];
    assign o_ovf = (i_sub ? (w_sa != w_sb) : (w_sa == w_sb)) && (w_ss != w_sa);
endmodule

module alu_pipe_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_lt_s,
    output logic             o_lt_u
);
    assign o_lt_s = $signed(i_a) < $signed(i_b);
    assign o_lt_u = i_a < i_b;
endmodule

module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf
);
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    logic             r_s1_valid;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_ovf;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic             w_as_ovf;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_accept = in_valid && in_ready;

    alu_pipe_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_sub (r_op == OP_SUB),
        .o_sum (w_sum),
        .o_ovf (w_as_ovf)
    );

    alu_pipe_cmp #(.WIDTH(WIDTH)) u_cmp (
        .i_a    (r_a),
        .i_b    (r_b),
        .o_lt_s (w_lt_s),
        .o_lt_u (w_lt_u)
    );

    always_comb begin
        w_res = r_op == OP_AND  ? (r_a & r_b) :
                r_op == OP_OR   ? (r_a | r_b) :
                r_op == OP_ADD  ? w_sum :
                r_op == OP_SUB  ? w_sum :
                r_op == OP_SLT  ? {{(WIDTH-1){1'b0}}, w_lt_s} :
                r_op == OP_SLTU ? {{(WIDTH-1){1'b0}}, w_lt_u} :
                r_op == OP_XOR  ? (r_a ^ r_b) :
                                  ~(r_a | r_b);
        w_ovf = (r_op == OP_ADD || r_op == OP_SUB) && w_as_ovf;
    end

    // flush clears only the valid bits; data registers keep their contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_op       <= op;
            r_a        <= A;
            r_b        <= B;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_res      <= w_res;
            r_zero     <= w_res == '0;
            r_ovf      <= w_ovf;
        end
    end

    assign out_valid = r_s2_valid;
    assign res       = r_res;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Two-stage pipelined ALU wrapper for the multiplexed arithmetic/logical unit. It accepts an opcode and two 32-bit operands through a valid/ready handshake and registers them in stage 1. Stage 2 evaluates the selected function (and, or, add, sub, slt, sltu, xor, nor) and registers the result with flags. It sits directly upstream of the register write-back logic and wraps the existing combinational function units, including the unsigned-compare unit.

## Interface
- WIDTH, 32, operand and result width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of both pipeline stages
- in_valid  input  1  request valid
- in_ready  output  1  block can accept request this cycle
- op  input  3  function select: 000 and, 001 or, 010 add, 011 sub, 100 slt, 101 sltu, 110 xor, 111 nor
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  res/zero/ovf valid
- out_ready  input  1  consumer accepts result
- res  output  WIDTH  result
- zero  output  1  res == 0
- ovf  output  1  signed overflow; add/sub only, 0 for all other ops

## Operation
- Stage 1 register holds s1_valid, op, A, B. Stage 2 register holds s2_valid, res, zero, ovf.
- s2_adv = !s2_valid || out_ready. s1_adv = !s1_valid || (s1_valid && s2_adv).
- in_ready = !s1_valid || s2_adv. It is combinational and never depends on in_valid.
- Accept occurs when in_valid && in_ready. On accept, stage 1 loads op/A/B and s1_valid <= 1.
- When s1_adv is true and there is no accept, s1_valid <= 0.
- When s2_adv is true, stage 2 loads the stage-1 computation and s2_valid <= s1_valid.
- Stage 2 holds its contents while out_valid && !out_ready. The res, zero and ovf outputs stay stable during this stall.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH.
  - ovf for add = (A[msb]==B[msb]) && (res[msb]!=A[msb]).
  - ovf for sub = (A[msb]!=B[msb]) && (res[msb]!=A[msb]).
  - slt is a signed compare and sltu an unsigned compare. Both give res = 1 when A < B, otherwise 0, zero-extended to WIDTH.
  - zero is computed from the final res of every op.
- flush has priority over accept and advance. It sets s1_valid <= 0 and s2_valid <= 0 at the next edge, and a request offered in the flush cycle is dropped. in_ready behaves normally during flush; the dropped request counts as not accepted by the producer contract, and the producer must re-offer it.
- Data registers are not cleared by flush. Only the valid bits are cleared.

## Timing
- Reset (rst_n low, asynchronous): s1_valid = 0, s2_valid = 0, out_valid = 0, res = 0, zero = 0, ovf = 0, in_ready = 1 (combinational from the cleared valids).
- Latency is 2 cycles: a request accepted at edge N appears with out_valid = 1 after edge N+2, provided out_ready has been held high.
- Throughput is one result per cycle with out_ready held high. Back-to-back accepts produce back-to-back results.
- Backpressure: with out_ready low, the pipeline fills after at most two accepts, then in_ready = 0.
  - Raising out_ready re-opens in_ready in the same cycle (combinational).
  - A simultaneous accept and output drain in a full pipeline is legal and loses nothing.
- Reset mid-operation discards all in-flight requests immediately.
- out_valid must never drop while out_ready is low, except on flush or reset.

## Test plan
- Reset, then op=101 with A=0x00000001, B=0xFFFFFFFF -> 2 cycles later out_valid=1, res=0x00000001. Same operands with op=100 -> res=0x00000000.
- Overflow: op=010 with A=0x7FFFFFFF, B=0x00000001 -> res=0x80000000, ovf=1, zero=0. Then op=011 with A=0x00000005, B=0x00000005 -> res=0, zero=1, ovf=0.
- Streaming: 8 back-to-back requests with out_ready=1 -> 8 consecutive out_valid cycles, results in order, first result 2 cycles after the first accept.
- Backpressure:
  - Setup: out_ready=0 while 3 requests are offered.
  - Required: exactly 2 accepted, in_ready=0, and res stays stable across the stall.
  - Then: out_ready=1 for 3 cycles -> all 3 results delivered in order, with no loss and no duplicate.
- Flush: with both stages full, assert flush for 1 cycle while in_valid=1 -> next cycle out_valid=0, and the flushed and offered requests never appear at the output.
- Async reset: assert rst_n=0 between clock edges with the pipeline full -> out_valid and res clear immediately, without waiting for a clock edge, and in_ready=1.
